// File: rtl/web0_lp_seq.sv
// Low-power entry/exit sequencer: four-phase pwr_req/pwr_ack handshake and a
// stretched clear_function pulse back to web0. Optional sleep-cycle counter: WEB0_LP_SEQ_SLEEP_CNT_EN.
module web0_lp_seq #(
    parameter int CLR_PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT      = 1024,
    parameter int SLEEP_CNT_W      = 32
) (
    input  logic                   clkclk,
    input  logic                   sysreset,
    input  logic                   wake,
    input  logic                   activate_low_pwr,
    input  logic                   epu_enable,
    input  logic                   pwr_ack,
    output logic                   pwr_req,
    output logic                   clear_function,
    output logic [2:0]             lp_state,
    output logic                   lp_err,
    output logic [SLEEP_CNT_W-1:0] sleep_cnt
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ENTER    = 3'd2,
        ST_SLEEP    = 3'd3,
        ST_EXIT     = 3'd4,
        ST_CLR_HI   = 3'd5,
        ST_CLR_LO   = 3'd6,
        ST_ERROR    = 3'd7
    } state_t;

    // A zero timeout still needs a one-bit timer so the declarations stay legal.
    localparam int               TMR_W      = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit               TMO_EN     = (ACK_TIMEOUT > 0);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMO_EN ? TMR_W'(ACK_TIMEOUT - 1) : '0;
    localparam logic [7:0]       PULSE_LOAD = 8'(CLR_PULSE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [7:0]       pulse_cnt;
    logic             timeout;
    logic             pulse_done;

    assign timeout    = TMO_EN && (timer == TMR_LAST);
    assign pulse_done = (pulse_cnt == 8'd0);
    assign lp_state   = state;

    // The ack test precedes the timeout test so an ack wins a simultaneous compare.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISABLED: if (epu_enable) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!epu_enable)                        state_nxt = ST_DISABLED;
                else if (activate_low_pwr && !wake)     state_nxt = ST_ENTER;
            end
            ST_ENTER: begin
                if (pwr_ack)      state_nxt = (wake || !epu_enable) ? ST_EXIT : ST_SLEEP;
                else if (timeout) state_nxt = ST_ERROR;
            end
            ST_SLEEP:  if (wake || !epu_enable) state_nxt = ST_EXIT;
            ST_EXIT: begin
                if (!pwr_ack)     state_nxt = ST_CLR_HI;
                else if (timeout) state_nxt = ST_ERROR;
            end
            ST_CLR_HI: if (pulse_done) state_nxt = ST_CLR_LO;
            ST_CLR_LO: if (pulse_done) state_nxt = epu_enable ? ST_IDLE : ST_DISABLED;
            ST_ERROR:  if (!epu_enable) state_nxt = ST_DISABLED;
            default:   state_nxt = ST_DISABLED;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet track the state with no extra lag.
    always_ff @(posedge clkclk or posedge sysreset) begin
        if (sysreset) begin
            state          <= ST_DISABLED;
            pwr_req        <= 1'b0;
            clear_function <= 1'b0;
            lp_err         <= 1'b0;
            timer          <= '0;
            pulse_cnt      <= 8'd0;
        end else begin
            state          <= state_nxt;
            pwr_req        <= (state_nxt == ST_ENTER) || (state_nxt == ST_SLEEP);
            clear_function <= (state_nxt == ST_CLR_HI);

            if (state_nxt == ST_ERROR)         lp_err <= 1'b1;
            else if (state_nxt == ST_DISABLED) lp_err <= 1'b0;

            if (state_nxt != state)
                timer <= '0;
            else if ((state == ST_ENTER || state == ST_EXIT) && timer != '1)
                timer <= timer + 1'b1;

            // Reloading with N-1 holds each clear phase for exactly N cycles.
            if (state_nxt != state && (state_nxt == ST_CLR_HI || state_nxt == ST_CLR_LO))
                pulse_cnt <= PULSE_LOAD;
            else if ((state == ST_CLR_HI || state == ST_CLR_LO) && !pulse_done)
                pulse_cnt <= pulse_cnt - 8'd1;
        end
    end

`ifdef WEB0_LP_SEQ_SLEEP_CNT_EN
    logic [SLEEP_CNT_W-1:0] sleep_cnt_q;

    always_ff @(posedge clkclk or posedge sysreset) begin
        if (sysreset)
            sleep_cnt_q <= '0;
        else if (state == ST_ENTER && state_nxt == ST_SLEEP)
            sleep_cnt_q <= '0;
        else if (state == ST_SLEEP && sleep_cnt_q != '1)
            sleep_cnt_q <= sleep_cnt_q + 1'b1;
    end

    assign sleep_cnt = sleep_cnt_q;
`else
    assign sleep_cnt = '0;
`endif

endmodule
